// File: rtl/arith_mmio_unit_if.sv
// Command/response bundle between the MMIO register router and arith_mmio_unit.
// The router drives the master side; the arithmetic unit takes the slave side.
interface arith_mmio_unit_if #(
  parameter int WIDTH = 32
);
  logic             input_valid;
  logic             input_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             acc_clear;
  logic             output_valid;
  logic             output_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             busy;

  modport master (
    output input_valid, op, x, y, acc_clear, output_ready,
    input  input_ready, output_valid, result, flag, busy
  );

  modport slave (
    input  input_valid, op, x, y, acc_clear, output_ready,
    output input_ready, output_valid, result, flag, busy
  );
endinterface

// File: rtl/arith_mmio_unit.sv
// Multi-op arithmetic engine (ADD/SUB/GCD/ACC) fed by a DEPTH-entry command FIFO.
// Define ARITH_MMIO_PERF_EN to add saturating perf_ops/perf_cycles counters.
module arith_mmio_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  arith_mmio_unit_if.slave  bus
`ifdef ARITH_MMIO_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_GCD = 2'd2;
  localparam logic [1:0] OP_ACC = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_fifo_op [DEPTH];
  logic [WIDTH-1:0] r_fifo_x  [DEPTH];
  logic [WIDTH-1:0] r_fifo_y  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_flag;
  logic [WIDTH-1:0] r_gcd_a;
  logic [WIDTH-1:0] r_gcd_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_not_full;
  logic             w_not_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_fire;
  logic             w_busy;
  logic [1:0]       w_head_op;
  logic [WIDTH-1:0] w_head_x;
  logic [WIDTH-1:0] w_head_y;
  logic [WIDTH:0]   w_add_sum;
  logic [WIDTH:0]   w_sub_diff;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH:0]   w_acc_sum;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_a_eq_b;
  logic             w_a_gt_b;

  assign w_not_full  = (r_count != FULL_CNT);
  assign w_not_empty = (r_count != '0);
  assign w_push      = bus.input_valid && w_not_full;
  assign w_fire      = (r_state == S_DONE) && bus.output_ready;
  // The head is taken either from IDLE or in the same edge a DONE result is consumed.
  assign w_pop       = w_not_empty && ((r_state == S_IDLE) || w_fire);
  assign w_busy      = w_not_empty || (r_state != S_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_fifo_op[gi] <= bus.op;
          r_fifo_x[gi]  <= bus.x;
          r_fifo_y[gi]  <= bus.y;
        end
      end
    end
  endgenerate

  assign w_head_op = r_fifo_op[r_rd_ptr];
  assign w_head_x  = r_fifo_x[r_rd_ptr];
  assign w_head_y  = r_fifo_y[r_rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_add_sum  = {1'b0, w_head_x} + {1'b0, w_head_y};
  assign w_sub_diff = {1'b0, w_head_x} - {1'b0, w_head_y};
  // A clear arriving on the same edge as an ACC pop zeroes the base before the add.
  assign w_acc_base = bus.acc_clear ? '0 : r_acc;
  assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, w_head_x};

  assign w_a_zero = (r_gcd_a == '0);
  assign w_b_zero = (r_gcd_b == '0);
  assign w_a_eq_b = (r_gcd_a == r_gcd_b);
  assign w_a_gt_b = (r_gcd_a > r_gcd_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_gcd_a  <= '0;
      r_gcd_b  <= '0;
    end else if (w_pop) begin
      case (w_head_op)
        OP_ADD: begin
          r_result <= w_add_sum[WIDTH-1:0];
          r_flag   <= w_add_sum[WIDTH];
          r_state  <= S_DONE;
        end
        OP_SUB: begin
          r_result <= w_sub_diff[WIDTH-1:0];
          r_flag   <= w_sub_diff[WIDTH];
          r_state  <= S_DONE;
        end
        OP_GCD: begin
          r_gcd_a  <= w_head_x;
          r_gcd_b  <= w_head_y;
          r_flag   <= 1'b0;
          r_state  <= S_EXEC;
        end
        default: begin
          r_result <= w_acc_sum[WIDTH-1:0];
          r_flag   <= w_acc_sum[WIDTH];
          r_state  <= S_DONE;
        end
      endcase
    end else if (w_fire) begin
      r_state <= S_IDLE;
    end else if (r_state == S_EXEC) begin
      // Subtractive Euclid: one compare/subtract per cycle, zero operands end it early.
      if (w_a_zero) begin
        r_result <= r_gcd_b;
        r_state  <= S_DONE;
      end else if (w_b_zero || w_a_eq_b) begin
        r_result <= r_gcd_a;
        r_state  <= S_DONE;
      end else if (w_a_gt_b) begin
        r_gcd_a <= r_gcd_a - r_gcd_b;
      end else begin
        r_gcd_b <= r_gcd_b - r_gcd_a;
      end
    end else if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
      r_state <= S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_pop && (w_head_op == OP_ACC)) begin
      r_acc <= w_acc_sum[WIDTH-1:0];
    end else if (bus.acc_clear) begin
      r_acc <= '0;
    end
  end

  assign bus.input_ready  = w_not_full;
  assign bus.output_valid = (r_state == S_DONE);
  assign bus.result       = r_result;
  assign bus.flag         = r_flag;
  assign bus.busy         = w_busy;

`ifdef ARITH_MMIO_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_ops    <= '0;
      r_perf_cycles <= '0;
    end else begin
      r_perf_ops    <= (w_fire && (r_perf_ops != '1)) ? r_perf_ops + 32'd1 : r_perf_ops;
      r_perf_cycles <= (w_busy && (r_perf_cycles != '1)) ? r_perf_cycles + 32'd1 : r_perf_cycles;
    end
  end

  assign perf_ops    = r_perf_ops;
  assign perf_cycles = r_perf_cycles;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
